// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: req/ack data-memory port, stall, load size masking, MEM/WB register
// Optional feature macro: MEM_TIMEOUT_EN (REQ abort counter and sticky dm_err)
module mem_access_stage #(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_ALU_result,
  input  logic [DATA_W-1:0] mem_ALU_B,
  input  logic [4:0]        mem_Rd,
  input  logic [1:0]        mem_WB,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [1:0]        dm_size,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic [4:0]        wb_Rd,
  output logic [1:0]        wb_WB,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign,
  output logic              dm_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [DATA_W-1:0]   dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic [1:0]          dm_size_q, dm_size_d;
  logic [4:0]          wb_Rd_q, wb_Rd_d;
  logic [1:0]          wb_WB_q, wb_WB_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;
  logic                stall_c;
  logic                mem_op;
  logic                addr_fault;
  logic                timeout_hit;
  logic [DATA_W-1:0]   size_mask;

  assign mem_op = mem_read | mem_write;

  always_comb begin
    addr_fault = 1'b0;
    case (mem_size)
      2'b01:   addr_fault = mem_ALU_result[0];
      2'b10:   addr_fault = |mem_ALU_result[1:0];
      2'b11:   addr_fault = |mem_ALU_result[2:0];
      default: addr_fault = 1'b0;
    endcase
  end

  always_comb begin
    size_mask = '1;
    case (dm_size_q)
      2'b00:   size_mask = DATA_W'(64'h0000_0000_0000_00FF);
      2'b01:   size_mask = DATA_W'(64'h0000_0000_0000_FFFF);
      2'b10:   size_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: size_mask = '1;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // cnt_q holds the number of REQ cycles already completed
  assign timeout_hit = (state_q == REQ) && !dm_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == REQ && !dm_ack && !timeout_hit) ? cnt_q + CNT_W'(1) : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign dm_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout_hit    = 1'b0;
  assign dm_err         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_size_d  = dm_size_q;
    wb_Rd_d    = wb_Rd_q;
    wb_WB_d    = wb_WB_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_Rd_d   = mem_Rd;
          wb_WB_d   = mem_WB;
          wb_data_d = mem_ALU_result;
        end else if (misalign_q) begin
          // faulted op is still held upstream; release it as a bubble
          wb_WB_d = 2'b00;
        end else begin
          stall_c = 1'b1;
          wb_WB_d = 2'b00;
          if (addr_fault) begin
            misalign_d = 1'b1;
          end else begin
            state_d    = REQ;
            dm_req_d   = 1'b1;
            dm_we_d    = mem_write;
            dm_addr_d  = mem_ALU_result;
            dm_wdata_d = mem_ALU_B;
            dm_size_d  = mem_size;
          end
        end
      end
      REQ: begin
        if (dm_ack) begin
          state_d  = IDLE;
          dm_req_d = 1'b0;
          wb_Rd_d  = mem_Rd;
          wb_WB_d  = dm_we_q ? 2'b00 : mem_WB;
          if (!dm_we_q) wb_data_d = dm_rdata & size_mask;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          dm_req_d = 1'b0;
          wb_WB_d  = 2'b00;
        end else begin
          stall_c = 1'b1;
          wb_WB_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) stall_c = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_size_q  <= 2'b00;
      wb_Rd_q    <= 5'd0;
      wb_WB_q    <= 2'b00;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_size_q  <= dm_size_d;
      wb_Rd_q    <= wb_Rd_d;
      wb_WB_q    <= wb_WB_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_size  = dm_size_q;
  assign stall    = stall_c;
  assign wb_Rd    = wb_Rd_q;
  assign wb_WB    = wb_WB_q;
  assign wb_data  = wb_data_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic [63:0] mem_ALU_result, mem_ALU_B;
  logic [4:0]  mem_Rd;
  logic [1:0]  mem_WB;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic [1:0]  dm_size;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        stall;
  logic [4:0]  wb_Rd;
  logic [1:0]  wb_WB;
  logic [63:0] wb_data;
  logic        misalign, dm_err;

  int          checks = 0;
  int          failures = 0;
  int          sc, rc;
  bit          done, mis, bub_bad;
  logic        we_seen;
  logic [63:0] wd_seen;

  mem_access_stage #(.DATA_W(64), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_ALU_result(mem_ALU_result), .mem_ALU_B(mem_ALU_B), .mem_Rd(mem_Rd), .mem_WB(mem_WB),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall), .wb_Rd(wb_Rd), .wb_WB(wb_WB),
    .wb_data(wb_data), .misalign(misalign), .dm_err(dm_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; mem_size = 0; mem_ALU_result = 0;
    mem_ALU_B = 0; mem_Rd = 0; mem_WB = 0;
  endtask

  // acts as the EX/MEM register plus memory model; called at a negedge
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] bdat,
                        input logic [4:0] rdr, input logic [1:0] wbc,
                        input int ack_at, input logic [63:0] rdat, input int bound);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_ALU_result = addr;
    mem_ALU_B = bdat; mem_Rd = rdr; mem_WB = wbc;
    sc = 0; rc = 0; done = 0; mis = 0; bub_bad = 0; we_seen = 0; wd_seen = 0;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (!stall) begin
        @(negedge clk);
        dm_ack = 0;
        done = 1;
        clear_inputs();
        break;
      end
      sc++;
      @(negedge clk);
      if (misalign) mis = 1;
      if (wb_WB !== 2'b00) bub_bad = 1;
      if (dm_req) begin
        rc++;
        we_seen = dm_we;
        wd_seen = dm_wdata;
        if (rc == ack_at) begin
          dm_ack = 1;
          dm_rdata = rdat;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 0; dm_ack = 0; dm_rdata = 0;
    clear_inputs();
    mem_read = 1;
    #2;
    checks++; if ({dm_req, dm_we, stall, misalign, dm_err} !== 5'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 00000", {dm_req, dm_we, stall, misalign, dm_err}); end
    checks++; if ({dm_addr, dm_wdata, dm_size} !== 130'd0) begin failures++; $display("FAIL reset_dm_bus: got %h expected 0", {dm_addr, dm_wdata, dm_size}); end
    checks++; if ({wb_Rd, wb_WB, wb_data} !== 71'd0) begin failures++; $display("FAIL reset_wb: got %h expected 0", {wb_Rd, wb_WB, wb_data}); end
    mem_read = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_alu_pass();
    run_op(0, 0, 2'b00, 64'h1234, 64'h0, 5'd5, 2'b01, 0, 64'h0, 4);
    checks++; if (done !== 1 || sc != 0) begin failures++; $display("FAIL alu_stall: got done=%0d stall_cycles=%0d expected 1/0", done, sc); end
    checks++; if (wb_data !== 64'h1234) begin failures++; $display("FAIL alu_data: got %h expected 1234", wb_data); end
    checks++; if ({wb_Rd, wb_WB} !== {5'd5, 2'b01}) begin failures++; $display("FAIL alu_rd_wb: got %h expected %h", {wb_Rd, wb_WB}, {5'd5, 2'b01}); end
  endtask

  task automatic test_load_dword();
    run_op(1, 0, 2'b11, 64'h40, 64'h0, 5'd7, 2'b11, 4, 64'hDEADBEEF_CAFEF00D, 20);
    checks++; if (done !== 1 || sc != 4 || rc != 4) begin failures++; $display("FAIL ld_timing: got done=%0d stall=%0d req=%0d expected 1/4/4", done, sc, rc); end
    checks++; if (bub_bad !== 0) begin failures++; $display("FAIL ld_bubbles: got nonzero wb_WB while stalled expected 00"); end
    checks++; if (wb_data !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("FAIL ld_data: got %h expected deadbeefcafef00d", wb_data); end
    checks++; if ({wb_Rd, wb_WB, dm_req} !== {5'd7, 2'b11, 1'b0}) begin failures++; $display("FAIL ld_wb: got %h expected %h", {wb_Rd, wb_WB, dm_req}, {5'd7, 2'b11, 1'b0}); end
  endtask

  task automatic test_size_mask();
    run_op(1, 0, 2'b00, 64'h41, 64'h0, 5'd1, 2'b11, 1, 64'hFFFF_FFFF_FFFF_FF80, 20);
    checks++; if (done !== 1 || sc != 1) begin failures++; $display("FAIL ldb_timing: got done=%0d stall=%0d expected 1/1", done, sc); end
    checks++; if (wb_data !== 64'h80) begin failures++; $display("FAIL ldb_data: got %h expected 80", wb_data); end
    run_op(1, 0, 2'b01, 64'h46, 64'h0, 5'd2, 2'b11, 2, 64'h0123_4567_89AB_CDEF, 20);
    checks++; if (wb_data !== 64'hCDEF) begin failures++; $display("FAIL ldh_data: got %h expected cdef", wb_data); end
    run_op(1, 0, 2'b10, 64'h44, 64'h0, 5'd3, 2'b11, 2, 64'h0123_4567_89AB_CDEF, 20);
    checks++; if (wb_data !== 64'h89AB_CDEF) begin failures++; $display("FAIL ldw_data: got %h expected 89abcdef", wb_data); end
  endtask

  task automatic test_store();
    run_op(0, 1, 2'b11, 64'h48, 64'h1122_3344_5566_7788, 5'd9, 2'b01, 2, 64'h0, 20);
    checks++; if (done !== 1 || we_seen !== 1) begin failures++; $display("FAIL st_we: got done=%0d we=%b expected 1/1", done, we_seen); end
    checks++; if (wd_seen !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL st_wdata: got %h expected 1122334455667788", wd_seen); end
    checks++; if (wb_WB !== 2'b00) begin failures++; $display("FAIL st_wb: got %b expected 00", wb_WB); end
  endtask

  task automatic test_misalign();
    run_op(1, 0, 2'b10, 64'h42, 64'h0, 5'd4, 2'b11, 1, 64'h0, 20);
    checks++; if (done !== 1 || sc != 1 || rc != 0) begin failures++; $display("FAIL mis_timing: got done=%0d stall=%0d req=%0d expected 1/1/0", done, sc, rc); end
    checks++; if (mis !== 1 || misalign !== 0) begin failures++; $display("FAIL mis_pulse: got seen=%0d now=%b expected 1/0", mis, misalign); end
    checks++; if (wb_WB !== 2'b00) begin failures++; $display("FAIL mis_wb: got %b expected 00", wb_WB); end
    run_op(0, 1, 2'b11, 64'h44, 64'h5, 5'd4, 2'b01, 1, 64'h0, 20);
    checks++; if (mis !== 1 || rc != 0) begin failures++; $display("FAIL mis_dword_st: got mis=%0d req=%0d expected 1/0", mis, rc); end
    run_op(1, 0, 2'b00, 64'h43, 64'h0, 5'd4, 2'b11, 1, 64'h7F, 20);
    checks++; if (mis !== 0 || wb_data !== 64'h7F) begin failures++; $display("FAIL byte_odd: got mis=%0d data=%h expected 0/7f", mis, wb_data); end
  endtask

  task automatic test_back_to_back();
    run_op(1, 0, 2'b11, 64'h50, 64'h0, 5'd10, 2'b11, 1, 64'hA5A5_0000_1111_2222, 20);
    checks++; if (wb_data !== 64'hA5A5_0000_1111_2222 || wb_Rd !== 5'd10) begin failures++; $display("FAIL b2b_ld: got %h/%0d expected a5a5000011112222/10", wb_data, wb_Rd); end
    run_op(0, 0, 2'b00, 64'h9999, 64'h0, 5'd11, 2'b01, 0, 64'h0, 4);
    checks++; if (wb_data !== 64'h9999 || sc != 0) begin failures++; $display("FAIL b2b_alu: got %h stall=%0d expected 9999/0", wb_data, sc); end
    run_op(0, 1, 2'b10, 64'h58, 64'hCAFE, 5'd12, 2'b01, 1, 64'h0, 20);
    checks++; if (sc != 1 || wd_seen !== 64'hCAFE || wb_WB !== 2'b00) begin failures++; $display("FAIL b2b_st: got stall=%0d wdata=%h wb=%b expected 1/cafe/00", sc, wd_seen, wb_WB); end
  endtask

  task automatic test_ack_idle();
    dm_ack = 1; dm_rdata = 64'hFFFF;
    mem_Rd = 5'd3; mem_WB = 2'b01; mem_ALU_result = 64'h55;
    #1;
    checks++; if (stall !== 0) begin failures++; $display("FAIL ack_idle_stall: got %b expected 0", stall); end
    @(negedge clk);
    dm_ack = 0;
    checks++; if (dm_req !== 0 || wb_data !== 64'h55) begin failures++; $display("FAIL ack_idle: got req=%b data=%h expected 0/55", dm_req, wb_data); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_req();
    run_op(1, 0, 2'b11, 64'h60, 64'h0, 5'd6, 2'b11, 0, 64'h0, 3);
    checks++; if (done !== 0 || dm_req !== 1) begin failures++; $display("FAIL rmid_pre: got done=%0d req=%b expected 0/1", done, dm_req); end
    #2 rst = 0;
    #1;
    checks++; if ({dm_req, stall, dm_we, misalign} !== 4'b0) begin failures++; $display("FAIL rmid_ctrl: got %b expected 0000", {dm_req, stall, dm_we, misalign}); end
    checks++; if ({dm_addr, wb_data, wb_WB, wb_Rd} !== 135'd0) begin failures++; $display("FAIL rmid_data: got %h expected 0", {dm_addr, wb_data, wb_WB, wb_Rd}); end
    clear_inputs();
    @(negedge clk);
    rst = 1;
    run_op(1, 0, 2'b10, 64'h68, 64'h0, 5'd8, 2'b11, 2, 64'hFFFF_FFFF_1234_5678, 20);
    checks++; if (done !== 1 || wb_data !== 64'h1234_5678 || wb_Rd !== 5'd8) begin failures++; $display("FAIL rmid_after: got done=%0d data=%h rd=%0d expected 1/12345678/8", done, wb_data, wb_Rd); end
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    run_op(1, 0, 2'b11, 64'h70, 64'h0, 5'd13, 2'b11, 0, 64'h0, 50);
    checks++; if (done !== 1 || rc != 4) begin failures++; $display("FAIL tmo_req: got done=%0d req_cycles=%0d expected 1/4", done, rc); end
    checks++; if (dm_req !== 0 || dm_err !== 1 || wb_WB !== 2'b00) begin failures++; $display("FAIL tmo_state: got req=%b err=%b wb=%b expected 0/1/00", dm_req, dm_err, wb_WB); end
    run_op(1, 0, 2'b00, 64'h78, 64'h0, 5'd14, 2'b01, 1, 64'h42, 20);
    checks++; if (dm_err !== 1 || wb_data !== 64'h42) begin failures++; $display("FAIL tmo_sticky: got err=%b data=%h expected 1/42", dm_err, wb_data); end
`else
    run_op(1, 0, 2'b11, 64'h70, 64'h0, 5'd13, 2'b11, 0, 64'h0, 1000);
    checks++; if (done !== 0 || rc != 1000 || dm_req !== 1) begin failures++; $display("FAIL no_tmo: got done=%0d req_cycles=%0d req=%b expected 0/1000/1", done, rc, dm_req); end
    checks++; if (dm_err !== 0 || stall !== 1) begin failures++; $display("FAIL no_tmo_err: got err=%b stall=%b expected 0/1", dm_err, stall); end
    rst = 0;
    clear_inputs();
    @(negedge clk);
    rst = 1;
`endif
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_load_dword();
    test_size_mask();
    test_store();
    test_misalign();
    test_back_to_back();
    test_ack_idle();
    test_reset_mid_req();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
